// File: rtl/stall_mem_pkg.sv
// Shared definitions for the stall_mem block.
// Holds the FSM state encoding, the request opcode, the counter width and the
// default values of the LATENCY / DEPTH_LOG2 parameters.
package stall_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } op_e;

  localparam int unsigned LatencyDefault   = 4;
  localparam int unsigned DepthLog2Default = 10;
  localparam int unsigned CtrWidth         = 4;

endpackage

// File: rtl/stall_mem_ctr.sv
// Latency down-counter for stall_mem.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, clears the count
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one; holds at zero
//   cnt_o      - current count
//   zero_o     - count is zero
module stall_mem_ctr
  import stall_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [CtrWidth-1:0] load_val_i,
  input  logic                dec_i,
  output logic [CtrWidth-1:0] cnt_o,
  output logic                zero_o
);

  logic [CtrWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stall_mem.sv
// Fixed-latency single-port memory with a stall handshake.
// A request (Rd xor Wr) is accepted in IDLE, held for LATENCY cycles while
// Stall is high, and completes with a one-cycle Done pulse. Writes commit on
// the Done cycle; read data is presented on DataOut only during Done.
// Optional feature: define STALL_MEM_ALIGN_ERR_EN to flag odd byte addresses
// as illegal requests.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset (storage is not cleared)
//   Addr    - byte address, word index = Addr[DEPTH_LOG2:1]
//   DataIn  - write data
//   Rd, Wr  - read / write request
//   DataOut - read data during Done, zero otherwise
//   Done    - completion pulse
//   Stall   - requester must hold its pipeline and request
//   err     - illegal request in IDLE (combinational)
module stall_mem
  import stall_mem_pkg::*;
#(
  parameter int unsigned LATENCY    = LatencyDefault,
  parameter int unsigned DEPTH_LOG2 = DepthLog2Default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;
  localparam logic [CtrWidth-1:0] LoadVal = CtrWidth'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [15:0]             data_q, data_d;
  op_e                     op_q, op_d;

  logic [15:0]             storage_q [Words];

  logic                    is_idle, is_busy, is_done;
  logic                    align_err, err_raw, accept;
  logic                    ctr_load, ctr_dec, ctr_zero;
  logic [CtrWidth-1:0]     ctr_cnt;
  logic                    mem_we;

  // Upper address bits beyond the storage depth wrap silently.
  logic unused_addr;
`ifdef STALL_MEM_ALIGN_ERR_EN
  assign unused_addr = ^Addr[15:DEPTH_LOG2+1];
`else
  assign unused_addr = ^{Addr[15:DEPTH_LOG2+1], Addr[0]};
`endif

  assign is_idle = (state_q == StIdle);
  assign is_busy = (state_q == StBusy);
  assign is_done = (state_q == StDone);

`ifdef STALL_MEM_ALIGN_ERR_EN
  assign align_err = Addr[0] & (Rd | Wr);
`else
  assign align_err = 1'b0;
`endif

  assign err_raw = is_idle & ((Rd & Wr) | align_err);
  assign accept  = ~rst & is_idle & (Rd ^ Wr) & ~err_raw;

  stall_mem_ctr u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ctr_load),
    .load_val_i (LoadVal),
    .dec_i      (ctr_dec),
    .cnt_o      (ctr_cnt),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = Addr[DEPTH_LOG2:1];
          data_d   = DataIn;
          op_d     = Wr ? OpWr : OpRd;
          ctr_load = 1'b1;
          state_d  = (LATENCY == 1) ? StDone : StBusy;
        end
      end
      StBusy: begin
        ctr_dec = 1'b1;
        // Leave BUSY as the count reaches zero so Done lands LATENCY cycles
        // after acceptance; zero is a guard against a stuck BUSY.
        if ((ctr_cnt == CtrWidth'(1)) || ctr_zero) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= OpRd;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

  // Gated by rst so an aborted write never reaches storage.
  assign mem_we = ~rst & is_done & (op_q == OpWr);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      storage_q[addr_q] <= data_q;
    end
  end

  assign Done    = ~rst & is_done;
  assign Stall   = ~rst & (is_busy | accept);
  assign err     = ~rst & err_raw;
  assign DataOut = (Done && (op_q == OpRd)) ? storage_q[addr_q] : 16'h0000;

endmodule

// File: tb/tb_stall_mem.sv
module tb_stall_mem;

  localparam int Lat   = 4;
  localparam int Words = 1024;
`ifdef STALL_MEM_ALIGN_ERR_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, err;

  logic [15:0] addr1, din1, dout1;
  logic        rd1, wr1, done1, stall1, err1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_m [Words];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  stall_mem #(.LATENCY(Lat), .DEPTH_LOG2(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .Rd      (Rd),
    .Wr      (Wr),
    .DataOut (DataOut),
    .Done    (Done),
    .Stall   (Stall),
    .err     (err)
  );

  stall_mem #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .Addr    (addr1),
    .DataIn  (din1),
    .Rd      (rd1),
    .Wr      (wr1),
    .DataOut (dout1),
    .Done    (done1),
    .Stall   (stall1),
    .err     (err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pops one expected response.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(Done), 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("dataout", 32'(DataOut), 32'(e));
      end
    end else begin
      chk("dataout_idle", 32'(DataOut), 32'd0);
    end
  end

  // Issue one request from IDLE (called #1 after a rising edge).
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
    bit e, acc;
    int idx;
    e   = (rd && wr) || (AlignEn && a[0] && (rd || wr));
    acc = (rd != wr) && !e;
    idx = (int'(a) / 2) % Words;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(negedge clk);
    chk("err", 32'(err), 32'(e));
    chk("stall_req", 32'(Stall), 32'(acc));
    if (acc) begin
      if (rd) begin
        exp_q.push_back(mem_m[idx]);
      end else begin
        exp_q.push_back(16'h0000);
        mem_m[idx] = d;
      end
    end
    @(posedge clk); #1;
    if (acc) begin
      for (int c = 1; c <= Lat; c++) begin
        // Junk on the inputs while a request is outstanding must be ignored.
        Rd = 1'($urandom); Wr = 1'($urandom);
        Addr = 16'($urandom); DataIn = 16'($urandom);
        @(negedge clk);
        chk("stall_busy", 32'(Stall), 32'(c < Lat));
        chk("done_time", 32'(Done), 32'(c == Lat));
        chk("err_busy", 32'(err), 32'd0);
        @(posedge clk); #1;
      end
    end
    Rd = 1'b0; Wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] al [4];
    logic [15:0] vals [4];
    logic [15:0] a;
    int r;

    rst = 1'b1; Rd = 1'b1; Wr = 1'b1; Addr = 16'h0001; DataIn = 16'h0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dataout", 32'(DataOut), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0;

    // Give the region used below known contents.
    for (int w = 0; w < 32; w++) do_req(1'b0, 1'b1, 16'(w * 2), 16'($urandom));

    // Write then read back, checking stall/done timing.
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Rd & Wr together: dropped with err.
    do_req(1'b1, 1'b1, 16'h0010, 16'h9999);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Reset during BUSY aborts the write.
    Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
    @(negedge clk);
    chk("abort_accept", 32'(Stall), 32'd1);
    @(posedge clk); #1;
    Wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_stall", 32'(Stall), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (Lat + 1) begin
      @(negedge clk);
      chk("abort_no_done", 32'(Done), 32'd0);
    end
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Address wrap modulo depth.
    do_req(1'b0, 1'b1, 16'h0802, 16'h5A5A);
    do_req(1'b1, 1'b0, 16'h0002, 16'h0000);

    // Odd address: illegal with alignment checking, word 8 otherwise.
    do_req(1'b0, 1'b1, 16'h0011, 16'h7777);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Randomized traffic, addresses confined to the initialized words.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      a = {5'($urandom), 5'b00000, 5'($urandom), 1'($urandom)};
      if (r < 4)       do_req(1'b1, 1'b0, a, 16'($urandom));
      else if (r < 8)  do_req(1'b0, 1'b1, a, 16'($urandom));
      else if (r == 8) do_req(1'b1, 1'b1, a, 16'($urandom));
      else             do_req(1'b0, 1'b0, a, 16'($urandom));
    end

    // LATENCY=1 instance: writes, then Rd held high continuously.
    for (int k = 0; k < 2; k++) begin
      wr1 = 1'b1; addr1 = 16'(2 * (k + 1)); din1 = (k == 0) ? 16'h1111 : 16'h2222;
      @(negedge clk);
      chk("l1_wstall", 32'(stall1), 32'd1);
      @(posedge clk); #1;
      wr1 = 1'b0;
      @(negedge clk);
      chk("l1_wdone", 32'(done1), 32'd1);
      @(posedge clk); #1;
    end
    al[0] = 16'h0002; al[1] = 16'h0004; al[2] = 16'h0002; al[3] = 16'h0004;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h1111; vals[3] = 16'h2222;
    rd1 = 1'b1; addr1 = al[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l1_done_pattern", 32'(done1), 32'(i % 2));
      if (i % 2 == 1) chk("l1_data", 32'(dout1), 32'(vals[i / 2]));
      else            chk("l1_stall_idle", 32'(stall1), 32'd1);
      @(posedge clk); #1;
      // Change address during DONE; must only be sampled in the next IDLE.
      if (i % 2 == 0) addr1 = al[i / 2 + 1];
    end
    rd1 = 1'b0;

    repeat (Lat + 2) @(posedge clk);
    @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_mem.md
STALL_MEM -- requirements
Module: stall_mem

Interface
REQ-001 SHALL have parameter: LATENCY, 4, cycles from request acceptance to Done (legal 1..15).
REQ-002 SHALL have parameter: DEPTH_LOG2, 10, log2 of storage depth in 16-bit words.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: Addr  input  16  byte address; word index = Addr[DEPTH_LOG2:1].
REQ-006 SHALL have port: DataIn  input  16  write data.
REQ-007 SHALL have port: Rd  input  1  read request.
REQ-008 SHALL have port: Wr  input  1  write request.
REQ-009 SHALL have port: DataOut  output  16  read data, valid only while Done=1.
REQ-010 SHALL have port: Done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: Stall  output  1  requester must hold the pipeline and its request.
REQ-012 SHALL have port: err  output  1  illegal-request flag, combinational.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL, in IDLE with exactly one of Rd/Wr high and err low, accept: latch Addr, DataIn, op; load counter with LATENCY-1; go to BUSY (go to DONE if LATENCY=1).
REQ-015 SHALL, in BUSY, decrement counter each cycle; at counter 0 go to DONE.
REQ-016 SHALL, in DONE, assert Done for exactly one cycle, then return to IDLE.
REQ-017 SHALL commit a write to storage on the DONE cycle, using the latched address and data only.
REQ-018 SHALL drive DataOut from storage at the latched address during DONE of a read; 16'h0000 otherwise.
REQ-019 SHALL drive Stall = (state==BUSY) | (state==IDLE & (Rd|Wr) & ~err); Stall SHALL be low during DONE.
REQ-020 SHALL ignore Rd/Wr/Addr/DataIn in BUSY and DONE; only one request is outstanding.
REQ-021 SHALL accept a new request in the IDLE cycle immediately after DONE (back-to-back period = LATENCY+1 cycles).
REQ-022 SHALL assert err when Rd & Wr in IDLE; the request is dropped and state remains IDLE.
REQ-023 SHALL wrap addresses above depth modulo 2^DEPTH_LOG2 words, without raising err.
REQ-024 SHALL leave storage unchanged on reads and on dropped requests.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, counter 0, latched fields 0, Done=0, Stall=0, DataOut=0, err=0.
REQ-026 SHALL abort an in-flight request on rst: no write commit, no Done pulse.
REQ-027 SHALL leave storage contents unaffected by rst.

Configuration
REQ-028 SHALL, with STALL_MEM_ALIGN_ERR_EN defined, treat Addr[0]=1 with Rd|Wr in IDLE as illegal: err=1, request dropped, no Stall.
REQ-029 SHALL, without STALL_MEM_ALIGN_ERR_EN, ignore Addr[0] entirely; err SHALL then reflect only REQ-022.

Structure
REQ-030 SHALL place the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the LATENCY/DEPTH_LOG2 defaults in shared package stall_mem_pkg.
REQ-031 SHALL implement the down-counter (load, decrement, zero flag, 4 bits) as sub-module stall_mem_ctr; storage and FSM SHALL stay in stall_mem.

Verification
REQ-032 SHALL cover: LATENCY=4, Wr Addr=16'h0010 DataIn=16'hBEEF, then Rd Addr=16'h0010 -> Stall high cycles 0-3 of each access, Done at cycle 4, DataOut=16'hBEEF.
REQ-033 SHALL cover: Rd & Wr both high in IDLE -> err=1 same cycle, Stall=0, no Done, storage unchanged.
REQ-034 SHALL cover: Wr Addr=16'h0020 DataIn=16'h1234, rst asserted in BUSY cycle 2 -> Done never pulses; subsequent Rd 16'h0020 returns the prior value, not 16'h1234.
REQ-035 SHALL cover: DEPTH_LOG2=10, Wr Addr=16'h0802 DataIn=16'h5A5A, Rd Addr=16'h0002 -> DataOut=16'h5A5A (wrap).
REQ-036 SHALL cover: Rd held high continuously, LATENCY=1 -> Done every 2nd cycle, Addr change during DONE not sampled until next IDLE.
REQ-037 SHALL cover: Wr Addr=16'h0011 -> with STALL_MEM_ALIGN_ERR_EN err=1 and no write; without it word 8 written.
